// File: rtl/instr_trace_buffer.sv
// rtl/instr_trace_buffer.sv - circular trace of retired (pc, instr) pairs with PC trigger and mnemonic readout
//
// Records the last DEPTH retirements from WB. A PC-match trigger captures POST_TRIG further
// retirements and then freezes the buffer. Reads return the stored entry plus an ASCII mnemonic.
// Optional feature macro: TRACE_SKIP_NOP_EN (retirements of the all-zero word are not recorded).
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   wb_valid, wb_pc, wb_instr   retirement stream from WB
//   trig_en, trig_pc            PC-match trigger arm and address
//   freeze, clear               force FROZEN / empty buffer and return to RECORD
//   rd_en, rd_idx               read request, 0 = newest entry
//   rd_hit, rd_pc, rd_instr     registered read result (zero on miss)
//   rd_ascii                    registered right-justified mnemonic
//   count, wrapped, state       occupancy, sticky overwrite flag, 00 RECORD / 01 POSTTRIG / 10 FROZEN
module instr_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int CHARS     = 6
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wb_valid,
  input  logic [31:0]                wb_pc,
  input  logic [31:0]                wb_instr,
  input  logic                       trig_en,
  input  logic [31:0]                trig_pc,
  input  logic                       freeze,
  input  logic                       clear,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       rd_hit,
  output logic [31:0]                rd_pc,
  output logic [31:0]                rd_instr,
  output logic [CHARS*8-1:0]         rd_ascii,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       wrapped,
  output logic [1:0]                 state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = CHARS * 8;

  typedef enum logic [1:0] {
    ST_RECORD   = 2'b00,
    ST_POSTTRIG = 2'b01,
    ST_FROZEN   = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wrapped_q, wrapped_d;
  logic [CW-1:0]   remain_q, remain_d;
  logic            rd_hit_q, rd_hit_d;
  logic [31:0]     rd_pc_q, rd_pc_d;
  logic [31:0]     rd_instr_q, rd_instr_d;
  logic [MW-1:0]   rd_ascii_q, rd_ascii_d;

  logic [31:0]     pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  logic            rec_ok;
  logic            wr_en;
  logic [AW-1:0]   rd_entry;
  logic            rd_in_range;

  // Names wider than CHARS keep their rightmost characters, narrower ones are zero-padded on the left.
  function automatic logic [MW-1:0] decode(input logic [31:0] w);
    logic [63:0]    m;
    logic [MW+63:0] ext;
    m = 64'("N-R");
    if (w == 32'h0)               m = 64'("NOP");
    else if (w == 32'h4200_0018)  m = 64'("ERET");
    else begin
      case (w[31:26])
        6'h00: begin
          case (w[5:0])
            6'h00: m = 64'("SLL");     6'h02: m = 64'("SRL");     6'h03: m = 64'("SRA");
            6'h04: m = 64'("SLLV");    6'h06: m = 64'("SRLV");    6'h07: m = 64'("SRAV");
            6'h08: m = 64'("JR");      6'h09: m = 64'("JALR");    6'h0C: m = 64'("SYSCALL");
            6'h0D: m = 64'("BREAK");   6'h10: m = 64'("MFHI");    6'h11: m = 64'("MTHI");
            6'h12: m = 64'("MFLO");    6'h13: m = 64'("MTLO");    6'h18: m = 64'("MULT");
            6'h19: m = 64'("MULTU");   6'h1A: m = 64'("DIV");     6'h1B: m = 64'("DIVU");
            6'h20: m = 64'("ADD");     6'h21: m = 64'("ADDU");    6'h22: m = 64'("SUB");
            6'h23: m = 64'("SUBU");    6'h24: m = 64'("AND");     6'h25: m = 64'("OR");
            6'h26: m = 64'("XOR");     6'h27: m = 64'("NOR");     6'h2A: m = 64'("SLT");
            6'h2B: m = 64'("SLTU");
            default: m = 64'("N-R");
          endcase
        end
        6'h01: begin
          case (w[20:16])
            5'b00000: m = 64'("BLTZ");
            5'b00001: m = 64'("BGEZ");
            5'b10000: m = 64'("BLTZAL");
            5'b10001: m = 64'("BGEZAL");
            default:  m = 64'("N-R");
          endcase
        end
        6'h02: m = 64'("J");       6'h03: m = 64'("JAL");     6'h04: m = 64'("BEQ");
        6'h05: m = 64'("BNE");     6'h06: m = 64'("BLEZ");    6'h07: m = 64'("BGTZ");
        6'h08: m = 64'("ADDI");    6'h09: m = 64'("ADDIU");   6'h0A: m = 64'("SLTI");
        6'h0B: m = 64'("SLTIU");   6'h0C: m = 64'("ANDI");    6'h0D: m = 64'("ORI");
        6'h0E: m = 64'("XORI");    6'h0F: m = 64'("LUI");
        6'h10: begin
          if (w[25:21] == 5'b00100)      m = 64'("MTC0");
          else if (w[25:21] == 5'b00000) m = 64'("MFC0");
          else                           m = 64'("N-R");
        end
        6'h20: m = 64'("LB");      6'h21: m = 64'("LH");      6'h23: m = 64'("LW");
        6'h24: m = 64'("LBU");     6'h25: m = 64'("LHU");     6'h28: m = 64'("SB");
        6'h29: m = 64'("SH");      6'h2B: m = 64'("SW");
        default: m = 64'("N-R");
      endcase
    end
    ext = {{MW{1'b0}}, m};
    return ext[MW-1:0];
  endfunction

  always_comb begin
`ifdef TRACE_SKIP_NOP_EN
    rec_ok = (wb_instr != 32'h0);
`else
    rec_ok = 1'b1;
`endif
    // clear and freeze both suppress this cycle's write
    wr_en = wb_valid && rec_ok && (state_q != ST_FROZEN) && !freeze && !clear;

    state_d   = state_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;
    remain_d  = remain_q;

    if (clear) begin
      state_d   = ST_RECORD;
      wptr_d    = '0;
      count_d   = '0;
      wrapped_d = 1'b0;
      remain_d  = '0;
    end else if (freeze) begin
      state_d = ST_FROZEN;
    end else if (wr_en) begin
      wptr_d = wptr_q + AW'(1);
      if (count_q == CW'(DEPTH)) wrapped_d = 1'b1;
      else                        count_d   = count_q + CW'(1);
      if (state_q == ST_POSTTRIG) begin
        remain_d = remain_q - CW'(1);
        if (remain_q == CW'(1)) state_d = ST_FROZEN;
      end else if (trig_en && (wb_pc == trig_pc)) begin
        remain_d = CW'(POST_TRIG);
        state_d  = (POST_TRIG == 0) ? ST_FROZEN : ST_POSTTRIG;
      end
    end

    // Reads see the contents before this cycle's write (memory updates non-blocking).
    rd_entry    = wptr_q - AW'(1) - rd_idx;
    rd_in_range = ({1'b0, rd_idx} < count_q);

    rd_hit_d   = rd_hit_q;
    rd_pc_d    = rd_pc_q;
    rd_instr_d = rd_instr_q;
    rd_ascii_d = rd_ascii_q;
    if (rd_en) begin
      rd_hit_d   = rd_in_range;
      rd_pc_d    = rd_in_range ? pc_mem_q[rd_entry] : 32'h0;
      rd_instr_d = rd_in_range ? instr_mem_q[rd_entry] : 32'h0;
      rd_ascii_d = rd_in_range ? decode(instr_mem_q[rd_entry]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_RECORD;
      wptr_q     <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      remain_q   <= '0;
      rd_hit_q   <= 1'b0;
      rd_pc_q    <= 32'h0;
      rd_instr_q <= 32'h0;
      rd_ascii_q <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      remain_q   <= remain_d;
      rd_hit_q   <= rd_hit_d;
      rd_pc_q    <= rd_pc_d;
      rd_instr_q <= rd_instr_d;
      rd_ascii_q <= rd_ascii_d;
    end
  end

  // Storage is not reset; count hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem_q[wptr_q]    <= wb_pc;
      instr_mem_q[wptr_q] <= wb_instr;
    end
  end

  assign rd_hit   = rd_hit_q;
  assign rd_pc    = rd_pc_q;
  assign rd_instr = rd_instr_q;
  assign rd_ascii = rd_ascii_q;
  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign state    = state_q;

endmodule
